// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: request/acknowledge bus between the fetch stage and instruction memory
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches over imem req/ack, holds the instruction, computes next PC on Retire
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    instr_fetch_unit_if.master         imem,
    input  logic [2:0]                 Branch,
    input  logic [1:0]                 Jump,
    input  logic                       Zero,
    input  logic [31:0]                RsData,
    input  logic                       Retire,
    output logic [31:0]                Instr,
    output logic [5:0]                 op,
    output logic [5:0]                 func,
    output logic [4:0]                 branop,
    output logic                       InstrValid,
    output logic [31:0]                PC,
    output logic [31:0]                PCplus4
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC} state_t;

    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_instr, w_next_pc, w_br_off;
    logic        r_valid, w_fetch, w_retire, w_taken, w_rs_neg, w_rs_zero;

    // handshake events only count in the state that expects them
    assign w_fetch   = (r_state == S_REQ) && imem.imem_ack;
    assign w_retire  = (r_state == S_EXEC) && Retire;

    assign w_rs_neg  = RsData[31];
    assign w_rs_zero = (RsData == 32'd0);
    assign w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    assign Instr      = r_instr;
    assign op         = r_instr[31:26];
    assign func       = r_instr[5:0];
    assign branop     = r_instr[20:16];
    assign InstrValid = r_valid;
    assign PC         = r_pc;
    assign PCplus4    = r_pc + 32'd4;
    assign imem.imem_addr = r_pc;

    // state register; reset parks the FSM in idle so a late ack is dropped
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // next state and request output; idle always moves on to fetching
    always_comb begin
        w_next_state  = S_IDLE;
        imem.imem_req = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                imem.imem_req = 1'b1;
                w_next_state  = w_fetch ? S_EXEC : S_REQ;
            end
            S_EXEC: w_next_state = w_retire ? S_REQ : S_EXEC;
            default: w_next_state = S_IDLE;
        endcase
    end

    // branch condition from the ctrl code; codes 000 and 111 never take
    always_comb begin
        w_taken = 1'b0;
        case (Branch)
            3'b001: w_taken = Zero;
            3'b010: w_taken = !Zero;
            3'b011: w_taken = !w_rs_neg;
            3'b100: w_taken = !w_rs_neg && !w_rs_zero;
            3'b101: w_taken = w_rs_neg || w_rs_zero;
            3'b110: w_taken = w_rs_neg;
            default: w_taken = 1'b0;
        endcase
    end

    // jumps beat branches; jump code 11 falls through as no jump
    always_comb begin
        w_next_pc = (Jump == 2'b01) ? {PCplus4[31:28], r_instr[25:0], 2'b00} :
                    (Jump == 2'b10) ? {RsData[31:2], 2'b00} :
                    w_taken         ? PCplus4 + w_br_off : PCplus4;
    end

    // PC and instruction latch; both stay frozen while the instruction is valid
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_fetch) begin
            r_instr <= imem.imem_rdata;
            r_valid <= 1'b1;
        end else if (w_retire) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors with hand-computed PCs for the fetch stage
module tb_instr_fetch_unit;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [2:0]  Branch = '0;
    logic [1:0]  Jump = '0;
    logic        Zero = 1'b0;
    logic [31:0] RsData = '0;
    logic        Retire = 1'b0;
    logic [31:0] Instr, PC, PCplus4;
    logic [5:0]  op, func;
    logic [4:0]  branop;
    logic        InstrValid;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .imem(bus.master),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .RsData(RsData), .Retire(Retire),
        .Instr(Instr), .op(op), .func(func), .branop(branop),
        .InstrValid(InstrValid), .PC(PC), .PCplus4(PCplus4)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word, input int waits);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("req_timeout", 32'(bus.imem_req), 32'd1);
        repeat (waits) tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack   = 1'b0;
    endtask

    task automatic retire(input logic [2:0] br, input logic [1:0] jp, input logic z, input logic [31:0] rs);
        Branch = br; Jump = jp; Zero = z; RsData = rs; Retire = 1'b1;
        tick();
        Branch = '0; Jump = '0; Zero = 1'b0; RsData = '0; Retire = 1'b0;
    endtask

    typedef struct { logic [2:0] code; logic [31:0] instr; logic [31:0] rs; logic taken; } bvec_t;
    bvec_t bv[12];

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bv[0]  = '{3'b100, 32'h1C00_0001, 32'h0000_0000, 1'b0};
        bv[1]  = '{3'b100, 32'h1C00_0001, 32'h0000_0001, 1'b1};
        bv[2]  = '{3'b100, 32'h1C00_0001, 32'h8000_0000, 1'b0};
        bv[3]  = '{3'b101, 32'h1800_0001, 32'h0000_0000, 1'b1};
        bv[4]  = '{3'b101, 32'h1800_0001, 32'h0000_0001, 1'b0};
        bv[5]  = '{3'b101, 32'h1800_0001, 32'h8000_0000, 1'b1};
        bv[6]  = '{3'b011, 32'h0401_0001, 32'h0000_0000, 1'b1};
        bv[7]  = '{3'b011, 32'h0401_0001, 32'h0000_0001, 1'b1};
        bv[8]  = '{3'b011, 32'h0401_0001, 32'h8000_0000, 1'b0};
        bv[9]  = '{3'b110, 32'h0400_0001, 32'h0000_0000, 1'b0};
        bv[10] = '{3'b110, 32'h0400_0001, 32'h0000_0001, 1'b0};
        bv[11] = '{3'b110, 32'h0400_0001, 32'h8000_0000, 1'b1};

        // reset state and first fetch with three wait cycles
        tick(); tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_pc", PC, 32'h3000);
        chk("rst_instr", Instr, 32'd0);
        Rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1_req", 32'(bus.imem_req), 32'd1);
            chk("t1_addr", bus.imem_addr, 32'h3000);
            if (i < 3) tick();
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3408_0005;
        tick();
        bus.imem_ack = 1'b0;
        chk("t1_instr", Instr, 32'h3408_0005);
        chk("t1_op", 32'(op), 32'h0D);
        chk("t1_valid", 32'(InstrValid), 32'd1);
        chk("t1_req_low", 32'(bus.imem_req), 32'd0);
        retire(3'b000, 2'b00, 1'b0, 32'd0);
        chk("t1_next_addr", bus.imem_addr, 32'h3004);
        chk("t1_next_req", 32'(bus.imem_req), 32'd1);
        chk("t1_retired", 32'(InstrValid), 32'd0);

        // beq backwards at 0x3010, taken and not taken
        repeat (3) begin fetch(32'd0, 0); retire(3'b000, 2'b00, 1'b0, 32'd0); end
        chk("t2_pc", PC, 32'h3010);
        fetch(32'h1000_FFFE, 1);
        retire(3'b001, 2'b00, 1'b1, 32'd0);
        chk("t2_beq_taken", PC, 32'h300C);
        fetch(32'd0, 0); retire(3'b000, 2'b00, 1'b0, 32'd0);
        fetch(32'h1000_FFFE, 0);
        retire(3'b001, 2'b00, 1'b0, 32'd0);
        chk("t2_beq_not", PC, 32'h3014);

        // sign/zero branches, each with imm16=1 so taken means +8
        exp_pc = 32'h3014;
        foreach (bv[k]) begin
            fetch(bv[k].instr, k % 3);
            if (k == 6) chk("t3_bgez_branop", 32'(branop), 32'h01);
            if (k == 9) chk("t3_bltz_op", 32'(op), 32'h01);
            retire(bv[k].code, 2'b00, 1'b0, bv[k].rs);
            exp_pc = exp_pc + (bv[k].taken ? 32'd8 : 32'd4);
            chk($sformatf("t3_br%0d", k), PC, exp_pc);
        end

        // reset while requesting
        chk("t5_req_before", 32'(bus.imem_req), 32'd1);
        Rst_n = 1'b0; #1;
        chk("t5_req_rst", 32'(bus.imem_req), 32'd0);
        chk("t5_pc_rst", PC, 32'h3000);
        tick(); Rst_n = 1'b1; tick();

        // jumps
        fetch(32'h0800_0C10, 0);
        retire(3'b000, 2'b01, 1'b0, 32'd0);
        chk("t4_j", PC, 32'h3040);
        fetch(32'd0, 0);
        retire(3'b000, 2'b10, 1'b0, 32'h0000_4007);
        chk("t4_jr", PC, 32'h4004);
        fetch(32'h0800_0C10, 0);
        retire(3'b001, 2'b01, 1'b1, 32'd0);
        chk("t4_j_over_beq", PC, 32'h3040);

        // reset in execute, late ack after release, spurious handshakes
        fetch(32'h1234_5678, 0);
        chk("t5_valid_before", 32'(InstrValid), 32'd1);
        Rst_n = 1'b0; #1;
        chk("t5_valid_rst", 32'(InstrValid), 32'd0);
        chk("t5_req_rst2", 32'(bus.imem_req), 32'd0);
        chk("t5_pc_rst2", PC, 32'h3000);
        tick();
        Rst_n = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_DEAD;
        tick();
        bus.imem_ack = 1'b0;
        chk("t5_late_ack", Instr, 32'd0);
        chk("t5_late_valid", 32'(InstrValid), 32'd0);
        retire(3'b000, 2'b01, 1'b0, 32'd0);
        chk("t5_spur_retire", PC, 32'h3000);
        fetch(32'h0000_0020, 0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBEEF_BEEF;
        tick();
        chk("t5_spur_ack", Instr, 32'h0000_0020);
        chk("t5_spur_ack_pc", PC, 32'h3000);
        Retire = 1'b1;
        tick();
        Retire = 1'b0; bus.imem_ack = 1'b0;
        chk("t5_both_pc", PC, 32'h3004);
        chk("t5_both_valid", 32'(InstrValid), 32'd0);

        // wrap at the top of the address space
        fetch(32'd0, 0);
        retire(3'b000, 2'b10, 1'b0, 32'hFFFF_FFFC);
        chk("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        fetch(32'd0, 0);
        chk("t6_pcplus4", PCplus4, 32'd0);
        retire(3'b000, 2'b00, 1'b0, 32'd0);
        chk("t6_addr_wrap", bus.imem_addr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
